// File: rtl/dtcm_responder_pkg.sv
// Shared definitions for the data TCM responder: geometry, size encodings,
// byte-mask generation and load result formatting.
package dtcm_responder_pkg;

    localparam int TCM_AW = 4;
    localparam int TCM_DW = 64;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } state_e;

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            SIZE_B:  m = 8'h01;
            SIZE_H:  m = 8'h03;
            SIZE_W:  m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    function automatic logic [63:0] load_extend(input logic [63:0] d, input logic [1:0] size,
                                                input logic usi);
        logic [63:0] r;
        case (size)
            SIZE_B:  r = usi ? {56'd0, d[7:0]}  : {{56{d[7]}}, d[7:0]};
            SIZE_H:  r = usi ? {48'd0, d[15:0]} : {{48{d[15]}}, d[15:0]};
            SIZE_W:  r = usi ? {32'd0, d[31:0]} : {{32{d[31]}}, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dtcm_responder_bank.sv
// One TCM bank: byte-masked synchronous write, registered read. Contents are
// never reset.
module dtcm_bank #(
    parameter int AW = 4,
    parameter int DW = 64
) (
    input  logic              CLK,
    input  logic              re,
    input  logic [AW-1:0]     idx,
    input  logic [DW/8-1:0]   wmask,
    input  logic [DW-1:0]     wdata,
    output logic [DW-1:0]     rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge CLK) begin
        for (int i = 0; i < DW/8; i++) begin
            if (wmask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    // Read port holds its value when idle so a stalled response stays stable.
    always_ff @(posedge CLK) begin
        if (re) rdata <= mem[idx];
    end

endmodule

// File: rtl/dtcm_responder.sv
// Data TCM responder: valid/ready LSU requests onto two interleaved banks,
// window-crossing accesses split into two bank cycles, one-entry response.
module dtcm_responder
    import dtcm_responder_pkg::*;
#(
    parameter int AW = TCM_AW,
    parameter int DW = TCM_DW
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [63:0]   req_addr,
    input  logic          req_wen,
    input  logic [1:0]    req_size,
    input  logic          req_usi,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    input  logic          flush,
    output logic          fsm_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; valid never depends on ready, payload is held while
    // valid is high and ready is low.

    state_e state_q, state_d;

    logic [3:0]     off;
    logic [AW-1:0]  line;
    logic [4:0]     span;
    logic [64:0]    end_addr;
    logic           cur_split, cur_err, accept;
    logic [31:0]    mask32;
    logic [255:0]   data256;

    assign off       = req_addr[3:0];
    assign line      = req_addr[4 +: AW];
    assign span      = {1'b0, off} + (5'd1 << req_size);
    assign cur_split = span > 5'd16;
    assign end_addr  = {1'b0, req_addr} + {61'd0, (4'd1 << req_size)} - 65'd1;
    assign cur_err   = |end_addr[64:4+AW];
    assign mask32    = {24'd0, size_mask(req_size)} << off;
    assign data256   = {192'd0, req_wdata} << {off, 3'b000};

    logic rsp_valid_q, rsp_valid_d;
    logic rsp_err_q, rsp_load_q, rsp_split_q, rsp_usi_q;
    logic [3:0]   rsp_off_q;
    logic [1:0]   rsp_size_q;
    logic [AW-1:0] split_idx_q;
    logic          split_wen_q;
    logic [15:0]   hmask_q;
    logic [127:0]  hdata_q;
    logic [127:0]  held_q;

    assign req_ready = (state_q == ST_IDLE) & ~flush & (~rsp_valid_q | rsp_ready);
    assign accept    = req_valid & req_ready;

    logic          bank_re;
    logic [AW-1:0] bank_idx;
    logic [7:0]    a_mask, b_mask;
    logic [63:0]   a_data, b_data, a_rdata, b_rdata;

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q & ~rsp_ready;
        bank_re     = 1'b0;
        bank_idx    = line;
        a_mask      = 8'd0;
        b_mask      = 8'd0;
        a_data      = data256[63:0];
        b_data      = data256[127:64];
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!cur_err) begin
                        bank_re = ~req_wen;
                        if (req_wen) begin
                            a_mask = mask32[7:0];
                            b_mask = mask32[15:8];
                        end
                        if (cur_split) state_d = ST_SPLIT;
                    end
                    rsp_valid_d = cur_err | ~cur_split;
                end
            end
            ST_SPLIT: begin
                // Second window; a store finishes even under flush.
                bank_idx = split_idx_q;
                a_data   = hdata_q[63:0];
                b_data   = hdata_q[127:64];
                if (split_wen_q) begin
                    a_mask = hmask_q[7:0];
                    b_mask = hmask_q[15:8];
                end else begin
                    bank_re = ~flush;
                end
                rsp_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) rsp_valid_d = 1'b0;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
            rsp_split_q <= 1'b0;
            rsp_usi_q   <= 1'b0;
            rsp_off_q   <= 4'd0;
            rsp_size_q  <= 2'd0;
            split_idx_q <= '0;
            split_wen_q <= 1'b0;
            hmask_q     <= 16'd0;
            hdata_q     <= 128'd0;
            held_q      <= 128'd0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            if (accept) begin
                rsp_err_q   <= cur_err;
                rsp_load_q  <= ~req_wen & ~cur_err;
                rsp_split_q <= cur_split & ~cur_err;
                rsp_usi_q   <= req_usi;
                rsp_off_q   <= off;
                rsp_size_q  <= req_size;
                split_idx_q <= line + AW'(1);
                split_wen_q <= req_wen;
                hmask_q     <= mask32[31:16];
                hdata_q     <= data256[255:128];
            end
            if (state_q == ST_SPLIT) held_q <= {b_rdata, a_rdata};
        end
    end

    dtcm_bank #(.AW(AW), .DW(DW)) u_bank_a (
        .CLK(CLK), .re(bank_re), .idx(bank_idx), .wmask(a_mask), .wdata(a_data), .rdata(a_rdata)
    );

    dtcm_bank #(.AW(AW), .DW(DW)) u_bank_b (
        .CLK(CLK), .re(bank_re), .idx(bank_idx), .wmask(b_mask), .wdata(b_data), .rdata(b_rdata)
    );

    // Split loads merge the held first window below the live second window.
    logic [127:0] win_now, win_lo;
    logic [255:0] win_cat;
    logic [63:0]  load_bytes;

    assign win_now    = {b_rdata, a_rdata};
    assign win_lo     = rsp_split_q ? held_q : win_now;
    assign win_cat    = {win_now, win_lo};
    assign load_bytes = 64'(win_cat >> {rsp_off_q, 3'b000});

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_load_q ? load_extend(load_bytes, rsp_size_q, rsp_usi_q) : 64'd0;
    assign fsm_state = (state_q == ST_SPLIT);

endmodule

// File: tb/tb_dtcm_responder.sv
// Directed bench for dtcm_responder: scoreboard of expected responses popped
// by an independent monitor, plus timing, back-pressure and flush checks.
module tb_dtcm_responder;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_usi;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        flush;
    logic        fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [64:0] exp_q[$];

    always #5 CLK = ~CLK;

    dtcm_responder dut (
        .CLK(CLK), .RSTn(RSTn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_size(req_size), .req_usi(req_usi), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .flush(flush), .fsm_state(fsm_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Monitor: every consumed response is matched against the scoreboard.
    always @(negedge CLK) begin
        if (RSTn === 1'b1 && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rdata 0x%h err %b, expected no response",
                         rsp_rdata, rsp_err);
            end else begin
                logic [64:0] e;
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e[63:0]);
                check("rsp_err", 64'(rsp_err), 64'(e[64]));
            end
        end
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic do_req(input logic [63:0] addr, input logic wen, input logic [1:0] size,
                          input logic usi, input logic [63:0] wdata, input logic push,
                          input logic [63:0] exp_data, input logic exp_err);
        logic got;
        got = 1'b0;
        if (push) exp_q.push_back({exp_err, exp_data});
        req_valid = 1'b1;
        req_addr  = addr;
        req_wen   = wen;
        req_size  = size;
        req_usi   = usi;
        req_wdata = wdata;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            got = req_ready;
            @(posedge CLK);
            #1;
            if (got) break;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept for addr 0x%h, expected accept", addr);
        end
        req_valid = 1'b0;
    endtask

    task automatic measure_lat(input string name, input int exp_lat);
        int lat;
        lat = 99;
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLK);
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
        check(name, 64'(lat), 64'(exp_lat));
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (exp_q.size() == 0 && !rsp_valid) begin
                done = 1'b1;
                break;
            end
            @(posedge CLK);
            #1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            check(name, 64'(rsp_valid), 64'd0);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        RSTn = 1'b0; req_valid = 1'b0; req_addr = '0; req_wen = 1'b0; req_size = '0;
        req_usi = 1'b0; req_wdata = '0; rsp_ready = 1'b1; flush = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RSTn = 1'b1;

        @(negedge CLK);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_err", 64'(rsp_err), 64'd0);
        check("reset_rsp_rdata", rsp_rdata, 64'd0);
        check("reset_req_ready", 64'(req_ready), 64'd1);
        check("reset_state", 64'(fsm_state), 64'd0);
        @(posedge CLK);
        #1;

        // Aligned dword store/load and byte/half/word extension.
        do_req(64'h18, 1, 3, 0, 64'h1122334455667788, 1, 64'd0, 0);
        do_req(64'h18, 0, 3, 0, 64'd0, 1, 64'h1122334455667788, 0);
        measure_lat("lat_load_dword", 1);
        do_req(64'h1B, 1, 0, 0, 64'h84, 1, 64'd0, 0);
        do_req(64'h1B, 0, 0, 0, 64'd0, 1, 64'hFFFFFFFFFFFFFF84, 0);
        do_req(64'h1B, 0, 0, 1, 64'd0, 1, 64'h0000000000000084, 0);
        do_req(64'h1A, 0, 1, 0, 64'd0, 1, 64'hFFFFFFFFFFFF8466, 0);
        do_req(64'h19, 0, 2, 1, 64'd0, 1, 64'h0000000044846677, 0);

        // Window-crossing word.
        do_req(64'h0E, 1, 2, 0, 64'hDEADBEEF, 1, 64'd0, 0);
        measure_lat("lat_split_store", 2);
        do_req(64'h0E, 0, 2, 0, 64'd0, 1, 64'hFFFFFFFFDEADBEEF, 0);
        measure_lat("lat_split_load", 2);
        do_req(64'h0E, 0, 0, 1, 64'd0, 1, 64'hEF, 0);
        do_req(64'h0F, 0, 0, 1, 64'd0, 1, 64'hBE, 0);
        do_req(64'h10, 0, 0, 1, 64'd0, 1, 64'hAD, 0);
        do_req(64'h11, 0, 0, 1, 64'd0, 1, 64'hDE, 0);

        // Range errors, with surrounding memory confirmed untouched.
        do_req(64'h00, 1, 3, 0, 64'hA0A1A2A3A4A5A6A7, 1, 64'd0, 0);
        do_req(64'hF8, 1, 3, 0, 64'h0102030405060708, 1, 64'd0, 0);
        do_req(64'hFC, 0, 3, 0, 64'd0, 1, 64'd0, 1);
        measure_lat("lat_err", 1);
        do_req(64'hFC, 1, 3, 0, 64'hFFFFFFFFFFFFFFFF, 1, 64'd0, 1);
        do_req(64'h1000000000000018, 0, 0, 0, 64'd0, 1, 64'd0, 1);
        do_req(64'hFF, 0, 1, 0, 64'd0, 1, 64'd0, 1);
        do_req(64'hFF, 0, 0, 1, 64'd0, 1, 64'h01, 0);
        do_req(64'hF8, 0, 3, 0, 64'd0, 1, 64'h0102030405060708, 0);
        do_req(64'h00, 0, 3, 0, 64'd0, 1, 64'hA0A1A2A3A4A5A6A7, 0);
        drain();

        // Back-pressure: response held three cycles, then same-cycle accept.
        rsp_ready = 1'b0;
        do_req(64'h18, 0, 3, 0, 64'd0, 1, 64'h1122334484667788, 0);
        exp_q.push_back({1'b0, 64'h84});
        req_valid = 1'b1; req_addr = 64'h1B; req_wen = 1'b0; req_size = 2'd0; req_usi = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            check("bp_rsp_rdata", rsp_rdata, 64'h1122334484667788);
            check("bp_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge CLK);
        #1 rsp_ready = 1'b1;
        @(negedge CLK);
        check("bp_release_ready", 64'(req_ready), 64'd1);
        @(posedge CLK);
        #1 req_valid = 1'b0;
        drain();

        // Flush in the second cycle of a split store: no response, all bytes land.
        do_req(64'h0C, 1, 3, 0, 64'h8877665544332211, 0, 64'd0, 0);
        flush = 1'b1;
        @(posedge CLK);
        #1 flush = 1'b0;
        expect_quiet("flush_store_quiet", 3);
        do_req(64'h0C, 0, 3, 0, 64'd0, 1, 64'h8877665544332211, 0);
        do_req(64'h10, 0, 2, 0, 64'd0, 1, 64'hFFFFFFFF88776655, 0);
        drain();

        // Flush in the second cycle of a split load: aborted, back to idle.
        do_req(64'h0C, 0, 3, 0, 64'd0, 0, 64'd0, 0);
        flush = 1'b1;
        @(posedge CLK);
        #1 flush = 1'b0;
        @(negedge CLK);
        check("flush_load_state", 64'(fsm_state), 64'd0);
        check("flush_load_ready", 64'(req_ready), 64'd1);
        expect_quiet("flush_load_quiet", 3);

        // Flush wins over a simultaneous request.
        req_valid = 1'b1; req_addr = 64'h00; req_wen = 1'b0; req_size = 2'd3; req_usi = 1'b0;
        flush = 1'b1;
        @(negedge CLK);
        check("flush_blocks_ready", 64'(req_ready), 64'd0);
        @(posedge CLK);
        #1 req_valid = 1'b0; flush = 1'b0;
        expect_quiet("flush_req_quiet", 2);

        // Back-to-back non-split loads.
        do_req(64'h0C, 0, 0, 1, 64'd0, 1, 64'h11, 0);
        do_req(64'h0D, 0, 0, 1, 64'd0, 1, 64'h22, 0);
        do_req(64'h13, 0, 0, 0, 64'd0, 1, 64'hFFFFFFFFFFFFFF88, 0);
        drain();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
